// File: rtl/instruction_fetch_pkg.sv
// Shared fetch-stage types: FSM state encoding and instruction size.
package FetchStatesPackage;

    typedef enum logic [2:0] {
        IDLE,
        REQUEST,
        WAIT,
        HOLD,
        DRAIN
    } FetchState;

    localparam int unsigned INSTRUCTION_BYTES = 4;

endpackage

// File: rtl/instruction_fetch_pc_register.sv
// Program counter for the fetch stage: reset vector, sequential increment and
// redirect load. Build macro IFETCH_ALIGN_CHECK_EN word-aligns redirect targets
// and raises a sticky addressError on a misaligned target; without it the
// target is loaded verbatim and addressError is tied low.
module pc_register
    import FetchStatesPackage::*;
#(
    parameter logic [31:0] RESET_VECTOR = 32'h0000_0000
)
(
    input  logic        clk,
    input  logic        rst,
    input  logic        load,
    input  logic [31:0] loadTarget,
    input  logic        increment,
    output logic [31:0] pc,
    output logic        addressError
);

    logic [31:0] pcReg;
    logic [31:0] pcNext;
    logic [31:0] loadValue;

`ifdef IFETCH_ALIGN_CHECK_EN
    logic errorReg;

    assign loadValue    = {loadTarget[31:2], 2'b00};
    assign addressError = errorReg;

    // Sticky misalignment flag, cleared only by reset
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            errorReg <= 1'b0;
        end else if (load && (loadTarget[1:0] != 2'b00)) begin
            errorReg <= 1'b1;
        end
    end
`else
    assign loadValue    = loadTarget;
    assign addressError = 1'b0;
`endif

    // Redirect wins over the sequential step; 32-bit wrap is intentional
    always_comb begin
        pcNext = pcReg;
        if (load) begin
            pcNext = loadValue;
        end else if (increment) begin
            pcNext = pcReg + 32'(INSTRUCTION_BYTES);
        end
    end

    // PC flop
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pcReg <= RESET_VECTOR;
        end else begin
            pcReg <= pcNext;
        end
    end

    assign pc = pcReg;

endmodule

// File: rtl/instruction_fetch.sv
// Fetch stage: single-outstanding instruction memory reads, holds the fetched
// word until decode consumes it, and honours branch-unit redirects by flushing
// whatever is held or in flight. Optional build macro: IFETCH_ALIGN_CHECK_EN
// (word-aligned redirects with sticky addressError).
module instruction_fetch
    import FetchStatesPackage::*;
#(
    parameter logic [31:0] RESET_VECTOR = 32'h0000_0000
)
(
    input  logic        clk,
    input  logic        rst,
    input  logic        shouldUseNewPC,
    input  logic [31:0] branchTo,
    input  logic        stall,
    output logic        imemRead,
    output logic [31:0] imemAddress,
    input  logic [31:0] imemReadData,
    input  logic        imemReady,
    output logic [31:0] instruction,
    output logic [31:0] pcAddress,
    output logic        instructionValid,
    output logic        addressError
);

    FetchState   stateReg;
    FetchState   stateNext;
    logic        pcIncrement;
    logic        captureData;
    logic        dropValid;
    logic [31:0] pc;
    logic [31:0] instructionReg;
    logic [31:0] pcAddressReg;
    logic        validReg;

    // A redirect always reloads the PC, whatever state we are in
    pc_register #(
        .RESET_VECTOR (RESET_VECTOR)
    ) pcRegister (
        .clk          (clk),
        .rst          (rst),
        .load         (shouldUseNewPC),
        .loadTarget   (branchTo),
        .increment    (pcIncrement),
        .pc           (pc),
        .addressError (addressError)
    );

    // FSM state register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stateReg <= IDLE;
        end else begin
            stateReg <= stateNext;
        end
    end

    // Next state and control strobes; redirect is checked first everywhere
    always_comb begin
        stateNext   = stateReg;
        pcIncrement = 1'b0;
        captureData = 1'b0;
        dropValid   = 1'b0;
        unique case (stateReg)
            IDLE: begin
                stateNext = REQUEST;
            end
            REQUEST: begin
                stateNext = shouldUseNewPC ? DRAIN : WAIT;
            end
            WAIT: begin
                if (shouldUseNewPC) begin
                    // A response arriving with the redirect is simply dropped
                    stateNext = imemReady ? REQUEST : DRAIN;
                end else if (imemReady) begin
                    captureData = 1'b1;
                    stateNext   = HOLD;
                end
            end
            HOLD: begin
                if (shouldUseNewPC) begin
                    dropValid = 1'b1;
                    stateNext = REQUEST;
                end else if (!stall) begin
                    dropValid   = 1'b1;
                    pcIncrement = 1'b1;
                    stateNext   = REQUEST;
                end
            end
            DRAIN: begin
                // A fresh redirect only moves the PC; the stale read still
                // has to come back before a new one may be issued
                if (imemReady) begin
                    stateNext = REQUEST;
                end
            end
            default: begin
                stateNext = IDLE;
            end
        endcase
    end

    // Output registers: capture on response, clear on consume or flush
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            instructionReg <= 32'h0000_0000;
            pcAddressReg   <= 32'h0000_0000;
            validReg       <= 1'b0;
        end else if (captureData) begin
            instructionReg <= imemReadData;
            pcAddressReg   <= pc;
            validReg       <= 1'b1;
        end else if (dropValid) begin
            validReg       <= 1'b0;
        end
    end

    assign imemRead         = (stateReg == REQUEST);
    assign imemAddress      = pc;
    assign instruction      = instructionReg;
    assign pcAddress        = pcAddressReg;
    assign instructionValid = validReg;

endmodule

// File: tb/tb_instruction_fetch.sv
// Bench for instruction_fetch: directed scenarios followed by random traffic,
// checked against a transaction-level model (outstanding read, held word,
// expected PC). A second instance covers the wrapping reset vector.
module tb_instruction_fetch;

    localparam logic [31:0] RV  = 32'h0000_0000;
    localparam logic [31:0] RV2 = 32'hFFFF_FFF8;
`ifdef IFETCH_ALIGN_CHECK_EN
    localparam bit ALIGN_EN = 1'b1;
`else
    localparam bit ALIGN_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        shouldUseNewPC = 1'b0;
    logic [31:0] branchTo = 32'h0;
    logic        stall = 1'b0;
    logic        imemRead;
    logic [31:0] imemAddress;
    logic [31:0] imemReadData = 32'h0;
    logic        imemReady = 1'b0;
    logic [31:0] instruction;
    logic [31:0] pcAddress;
    logic        instructionValid;
    logic        addressError;

    logic        read2;
    logic [31:0] addr2;
    logic [31:0] data2;
    logic        ready2;
    logic [31:0] insn2;
    logic [31:0] pcAddr2;
    logic        valid2;
    logic        err2;

    always #5 clk = ~clk;

    instruction_fetch #(.RESET_VECTOR(RV)) dut (
        .clk (clk), .rst (rst), .shouldUseNewPC (shouldUseNewPC), .branchTo (branchTo),
        .stall (stall), .imemRead (imemRead), .imemAddress (imemAddress),
        .imemReadData (imemReadData), .imemReady (imemReady), .instruction (instruction),
        .pcAddress (pcAddress), .instructionValid (instructionValid), .addressError (addressError)
    );

    instruction_fetch #(.RESET_VECTOR(RV2)) dut2 (
        .clk (clk), .rst (rst), .shouldUseNewPC (1'b0), .branchTo (32'h0),
        .stall (1'b0), .imemRead (read2), .imemAddress (addr2),
        .imemReadData (data2), .imemReady (ready2), .instruction (insn2),
        .pcAddress (pcAddr2), .instructionValid (valid2), .addressError (err2)
    );

    function automatic logic [31:0] memData(input logic [31:0] a);
        return {a[15:0], a[31:16]} ^ 32'h1357_9BDF;
    endfunction

    function automatic logic [31:0] alignTarget(input logic [31:0] t);
        return ALIGN_EN ? {t[31:2], 2'b00} : t;
    endfunction

    // One-cycle memory for the second instance, plus logs of its traffic
    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            ready2 <= 1'b0;
            data2  <= 32'h0;
        end else begin
            ready2 <= read2;
            data2  <= memData(addr2);
        end
    end

    logic [31:0] addrLog[$];
    logic [31:0] validAddrLog[$];
    logic [31:0] validInsnLog[$];
    always @(negedge clk) begin
        if (rst) begin
            if (read2) addrLog.push_back(addr2);
            if (valid2) begin
                validAddrLog.push_back(pcAddr2);
                validInsnLog.push_back(insn2);
            end
        end
    end

    // Reference model state
    bit          mStarted, mReqNow, mOutstanding, mFlushed, mHeld, mErr;
    logic [31:0] mPc, mReadAddr, mInsn, mInsnAddr;
    // Memory environment state
    bit          memBusy;
    int          memWait;
    logic [31:0] memAddr;
    int          memLatency;
    bit          randomLatency;
    int          spuriousPct;

    int checkCount = 0;
    int passCount  = 0;
    int cycle      = 0;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checkCount++;
        assert (got === exp) passCount++;
        else $error("FAIL %s cycle=%0d observed=%h expected=%h", name, cycle, got, exp);
    endtask

    task automatic modelReset();
        mStarted = 0; mReqNow = 0; mOutstanding = 0; mFlushed = 0; mHeld = 0; mErr = 0;
        mPc = RV; mReadAddr = 32'h0; mInsn = 32'h0; mInsnAddr = 32'h0;
        memBusy = 0; memWait = 0; memAddr = 32'h0;
    endtask

    // Called at a negedge; asserts reset mid-cycle and releases it on a later negedge
    task automatic doReset();
        #2 rst = 1'b0;
        #1;
        check("rstImemRead", 32'(imemRead), 32'd0);
        check("rstImemAddress", imemAddress, RV);
        check("rstValid", 32'(instructionValid), 32'd0);
        check("rstInstruction", instruction, 32'd0);
        check("rstPcAddress", pcAddress, 32'd0);
        check("rstAddressError", 32'(addressError), 32'd0);
        stall = 1'b0; shouldUseNewPC = 1'b0; imemReady = 1'b0;
        modelReset();
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
    endtask

    // One clock cycle: respond from memory, check outputs, drive inputs, advance model
    task automatic stepCycle(input logic stallIn, input logic redirIn, input logic [31:0] target);
        logic rdy;
        logic reqNext;
        logic consume;
        rdy = 1'b0;
        imemReadData = 32'hDEAD_BEEF;
        if (memBusy) begin
            memWait--;
            if (memWait == 0) begin
                rdy = 1'b1;
                imemReadData = memData(memAddr);
                memBusy = 0;
            end
        end else if (mHeld && !mOutstanding && ($urandom_range(0, 99) < 32'(spuriousPct))) begin
            rdy = 1'b1;
            imemReadData = $urandom;
        end

        check("imemRead", 32'(imemRead), 32'(mReqNow));
        check("imemAddress", imemAddress, mPc);
        check("instructionValid", 32'(instructionValid), 32'(mHeld));
        if (mHeld) begin
            check("instruction", instruction, mInsn);
            check("pcAddress", pcAddress, mInsnAddr);
        end
        check("addressError", 32'(addressError), 32'(mErr));

        stall = stallIn;
        shouldUseNewPC = redirIn;
        branchTo = target;
        imemReady = rdy;

        if (imemRead) begin
            memBusy = 1;
            memAddr = imemAddress;
            memWait = randomLatency ? int'($urandom_range(1, 4)) : memLatency;
        end

        reqNext = 1'b0;
        consume = mHeld && !stallIn && !redirIn;
        if (!mStarted) begin
            mStarted = 1;
            reqNext = 1'b1;
        end else if (mReqNow) begin
            mOutstanding = 1;
            mFlushed = redirIn;
            mReadAddr = mPc;
        end else if (mOutstanding) begin
            if (rdy) begin
                mOutstanding = 0;
                if (mFlushed || redirIn) begin
                    reqNext = 1'b1;
                end else begin
                    mHeld = 1;
                    mInsn = memData(mReadAddr);
                    mInsnAddr = mReadAddr;
                end
            end else if (redirIn) begin
                mFlushed = 1;
            end
        end else if (mHeld) begin
            if (redirIn || !stallIn) begin
                mHeld = 0;
                reqNext = 1'b1;
            end
        end
        if (redirIn) begin
            mPc = alignTarget(target);
            if (ALIGN_EN && (target[1:0] != 2'b00)) mErr = 1;
        end else if (consume) begin
            mPc = mPc + 32'd4;
        end
        mReqNow = reqNext;

        @(negedge clk);
        cycle++;
    endtask

    initial begin
        bit reached;
        memLatency = 1; randomLatency = 0; spuriousPct = 0;
        modelReset();
        @(negedge clk);
        doReset();

        // 1-cycle memory, no stall: reads at 0x0, 0x4, 0x8
        repeat (12) stepCycle(1'b0, 1'b0, 32'h0);

        // Wrapping reset vector on the second instance
        check("dut2ReadCount", 32'(addrLog.size() >= 3), 32'd1);
        if (addrLog.size() >= 3) begin
            check("dut2Read0", addrLog[0], 32'hFFFF_FFF8);
            check("dut2Read1", addrLog[1], 32'hFFFF_FFFC);
            check("dut2Read2", addrLog[2], 32'h0000_0000);
        end
        check("dut2ValidCount", 32'(validAddrLog.size() >= 1), 32'd1);
        if (validAddrLog.size() >= 1) begin
            check("dut2PcAddress0", validAddrLog[0], 32'hFFFF_FFF8);
            check("dut2Insn0", validInsnLog[0], memData(32'hFFFF_FFF8));
        end
        check("dut2AddressError", 32'(err2), 32'd0);

        // Stall for 5 cycles in HOLD, then release
        for (int i = 0; i < 6 && !mHeld; i++) stepCycle(1'b0, 1'b0, 32'h0);
        check("reachHold", 32'(instructionValid), 32'd1);
        repeat (5) stepCycle(1'b1, 1'b0, 32'h0);
        repeat (4) stepCycle(1'b0, 1'b0, 32'h0);

        // Redirect while waiting on a 4-cycle memory
        memLatency = 4;
        for (int i = 0; i < 12 && !(mOutstanding && !mReqNow); i++) stepCycle(1'b0, 1'b0, 32'h0);
        reached = mOutstanding && !mReqNow;
        check("reachWait", 32'(reached), 32'd1);
        stepCycle(1'b0, 1'b1, 32'hAABB_CCDC);
        repeat (12) stepCycle(1'b0, 1'b0, 32'h0);

        // Redirect in HOLD with stall low
        memLatency = 1;
        for (int i = 0; i < 12 && !mHeld; i++) stepCycle(1'b0, 1'b0, 32'h0);
        check("reachHold2", 32'(instructionValid), 32'd1);
        stepCycle(1'b0, 1'b1, 32'hABCD_ABCC);
        repeat (6) stepCycle(1'b0, 1'b0, 32'h0);

        // Misaligned redirect, then reset clears the sticky flag
        for (int i = 0; i < 12 && !mHeld; i++) stepCycle(1'b0, 1'b0, 32'h0);
        stepCycle(1'b0, 1'b1, 32'h0000_1003);
        repeat (8) stepCycle(1'b0, 1'b0, 32'h0);
        doReset();
        repeat (6) stepCycle(1'b0, 1'b0, 32'h0);

        // Random traffic with variable latency, stalls, redirects and resets
        randomLatency = 1; spuriousPct = 20;
        for (int i = 0; i < 1500; i++) begin
            logic s;
            logic r;
            logic [31:0] t;
            if (i == 700 || i == 1200) doReset();
            s = ($urandom_range(0, 99) < 35);
            r = ($urandom_range(0, 99) < 8);
            t = $urandom;
            if ($urandom_range(0, 3) != 0) t[1:0] = 2'b00;
            stepCycle(s, r, t);
        end

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
